// File: rtl/la_trace_decoder.sv
// la_trace_decoder: expands run-length LA trace packets {rc, sample} back into
// one sample per cycle. Null (all-zero) packets and malformed packets (rc==0,
// non-zero payload) each become a single gap sample marking lost data.
// Optional statistics counters are built when LA_DEC_STATS_EN is defined;
// otherwise pkt_cnt/gap_cnt/err_cnt/err_flag are tied to 0.
module la_trace_decoder #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned RC_W   = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [1:0]        s_tuser,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              smp_gap,
  output logic              smp_last,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  gap_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t            state_q, state_n;
  logic [RC_W-1:0]   remain_q, remain_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              gap_q, gap_n;
  logic              last_q, last_n;
  logic              slast_q, slast_n;
  logic              load;

  logic [RC_W-1:0]   pkt_rc;
  logic              pkt_rc_zero;
  logic              remain_one;
  logic              accept;

  // s_tuser carries no meaning here; fold it (and any bits outside the fields) away
  logic unused_in;
  assign unused_in = ^{s_tuser, s_tdata};

  assign pkt_rc      = s_tdata[31 -: RC_W];
  assign pkt_rc_zero = (pkt_rc == '0);
  assign remain_one  = (remain_q == RC_W'(1));

  // Ready when idle, or when the last sample of the current run is being consumed
  assign s_tready  = (state_q == IDLE) | ((state_q == EXPAND) & remain_one & smp_ready);
  assign accept    = s_tvalid & s_tready;

  assign smp_valid = (state_q == EXPAND);
  assign smp_data  = data_q;
  assign smp_gap   = gap_q;
  assign smp_last  = slast_q;

  // State, sample and run-length registers
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      data_q   <= '0;
      gap_q    <= 1'b0;
      last_q   <= 1'b0;
      slast_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      remain_q <= remain_n;
      data_q   <= data_n;
      gap_q    <= gap_n;
      last_q   <= last_n;
      slast_q  <= slast_n;
    end
  end

  // Next-state: count down the run, chain into the next packet with no bubble
  always_comb begin
    state_n  = state_q;
    remain_n = remain_q;
    data_n   = data_q;
    gap_n    = gap_q;
    last_n   = last_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      EXPAND: begin
        if (smp_ready) begin
          if (!remain_one) begin
            remain_n = remain_q - RC_W'(1);
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_n  = IDLE;
            remain_n = '0;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        remain_n = '0;
      end
    endcase

    if (load) begin
      state_n = EXPAND;
      last_n  = s_tlast;
      if (!pkt_rc_zero) begin
        data_n   = s_tdata[DATA_W-1:0];
        gap_n    = 1'b0;
        remain_n = pkt_rc;
      end else begin
        // null or malformed: a single gap sample
        data_n   = '0;
        gap_n    = 1'b1;
        remain_n = RC_W'(1);
      end
    end

    slast_n = last_n & (remain_n == RC_W'(1)) & (state_n == EXPAND);
  end

`ifdef LA_DEC_STATS_EN
  logic             pkt_null;
  logic             pkt_bad;
  logic [CNT_W-1:0] pkt_cnt_q, gap_cnt_q, err_cnt_q;
  logic             err_flag_q;

  assign pkt_null = (s_tdata == 32'h0);
  assign pkt_bad  = pkt_rc_zero & ~pkt_null;

  // Saturating statistics counters and sticky malformed-packet flag
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      pkt_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (accept) begin
      if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      if (pkt_null && gap_cnt_q != '1) gap_cnt_q <= gap_cnt_q + CNT_W'(1);
      if (pkt_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (pkt_bad) err_flag_q <= 1'b1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign gap_cnt  = gap_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
`else
  assign pkt_cnt  = '0;
  assign gap_cnt  = '0;
  assign err_cnt  = '0;
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_la_trace_decoder.sv
// Bench for la_trace_decoder: a packet-level model expands each packet into the
// list of samples it should produce; observed handshakes are compared against it.
module tb_la_trace_decoder;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [1:0]  s_tuser;
  logic [23:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic        smp_gap;
  logic        smp_last;
  logic [15:0] pkt_cnt, gap_cnt, err_cnt;
  logic        err_flag;

  la_trace_decoder dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .smp_data (smp_data),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .smp_gap  (smp_gap),
    .smp_last (smp_last),
    .pkt_cnt  (pkt_cnt),
    .gap_cnt  (gap_cnt),
    .err_cnt  (err_cnt),
    .err_flag (err_flag)
  );

  always #5 axis_clk = ~axis_clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [32:0] pkt_q[$];   // {tlast, tdata} still to send
  logic [25:0] exp_q[$];   // {last, gap, data} expected samples
  logic [25:0] obs_q[$];   // {last, gap, data} observed samples
  int          acc_cyc[$];
  int          hs_cyc[$];
  int          stall_bad;
  int          tready_busy;

  int   m_pkt, m_gap, m_err;
  logic m_errf;

  // Reference model: one packet -> list of samples and stat increments
  function automatic void model_push(logic [31:0] p, logic last);
    int rc;
    rc = int'(p[31:24]);
    pkt_q.push_back({last, p});
    m_pkt++;
    if (rc == 0) begin
      exp_q.push_back({last, 1'b1, 24'h0});
      if (p == 32'h0) m_gap++;
      else begin m_err++; m_errf = 1'b1; end
    end else begin
      for (int i = 1; i <= rc; i++)
        exp_q.push_back({(i == rc) ? last : 1'b0, 1'b0, p[23:0]});
    end
  endfunction

  function automatic logic [48:0] exp_stats();
`ifdef LA_DEC_STATS_EN
    return {16'(m_pkt), 16'(m_gap), 16'(m_err), m_errf};
`else
    return 49'h0;
`endif
  endfunction

  function automatic void model_reset();
    m_pkt = 0; m_gap = 0; m_err = 0; m_errf = 1'b0;
  endfunction

  function automatic void clear_run();
    pkt_q.delete(); exp_q.delete(); obs_q.delete();
    acc_cyc.delete(); hs_cyc.delete();
    stall_bad = 0; tready_busy = 0;
  endfunction

  // Drives queued packets and a sink-ready pattern (0: always, 1: toggle, 2: random)
  task automatic run_stream(input int mode);
    int          budget;
    logic        prev_stall;
    logic [24:0] prev_smp;
    budget = 0; prev_stall = 1'b0; prev_smp = '0;
    while (pkt_q.size() > 0 || obs_q.size() < exp_q.size()) begin
      @(negedge axis_clk);
      cyc++; budget++;
      if (budget > 3000) begin
        n_vec++; n_bad++;
        $display("FAIL run_stream timeout: got %0d samples, want %0d", obs_q.size(), exp_q.size());
        break;
      end
      case (mode)
        0:       smp_ready = 1'b1;
        1:       smp_ready = cyc[0];
        default: smp_ready = 1'($urandom_range(0, 1));
      endcase
      if (pkt_q.size() > 0) begin
        s_tvalid = 1'b1;
        {s_tlast, s_tdata} = pkt_q[0];
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0;
      end
      #1;
      if (prev_stall && (!smp_valid || {smp_gap, smp_data} != prev_smp)) stall_bad++;
      if (smp_valid && s_tready) tready_busy++;
      if (smp_valid && smp_ready) begin
        obs_q.push_back({smp_last, smp_gap, smp_data});
        hs_cyc.push_back(cyc);
      end
      if (s_tvalid && s_tready) begin
        void'(pkt_q.pop_front());
        acc_cyc.push_back(cyc);
      end
      prev_stall = smp_valid && !smp_ready;
      prev_smp   = {smp_gap, smp_data};
    end
    @(negedge axis_clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0; smp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    s_tvalid = 1'b0; s_tdata = 32'h0; s_tlast = 1'b0; s_tuser = 2'b00; smp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge axis_clk);
    #1;
    n_vec++;
    if ({smp_valid, smp_gap, smp_last, smp_data} !== 27'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {smp_valid, smp_gap, smp_last, smp_data});
    end
    n_vec++;
    if (s_tready !== 1'b1) begin n_bad++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    n_vec++;
    if ({pkt_cnt, gap_cnt, err_cnt, err_flag} !== 49'h0) begin
      n_bad++; $display("FAIL reset_stats: got %h want 0", {pkt_cnt, gap_cnt, err_cnt, err_flag});
    end
    @(negedge axis_clk);
    axis_rst = 1'b0;
  endtask

  task automatic test_single_run();
    clear_run();
    model_push(32'h03ABCDEF, 1'b0);
    run_stream(0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL single_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (acc_cyc.size() == 1 && hs_cyc.size() == 3) begin
      n_vec++;
      if (hs_cyc[0] - acc_cyc[0] != 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1", hs_cyc[0] - acc_cyc[0]); end
      n_vec++;
      if (hs_cyc[2] - hs_cyc[0] != 2) begin n_bad++; $display("FAIL single_span: got %0d want 2", hs_cyc[2] - hs_cyc[0]); end
    end
    n_vec++;
    if (smp_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", smp_valid); end
    n_vec++;
    if ({pkt_cnt, gap_cnt, err_cnt, err_flag} !== exp_stats()) begin
      n_bad++; $display("FAIL single_stats: got %h want %h", {pkt_cnt, gap_cnt, err_cnt, err_flag}, exp_stats());
    end
  endtask

  task automatic test_back_to_back();
    clear_run();
    model_push(32'h02000001, 1'b0);
    model_push(32'h01000002, 1'b0);
    run_stream(0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (acc_cyc.size() == 2 && hs_cyc.size() == 3) begin
      n_vec++;
      if (acc_cyc[1] != hs_cyc[1]) begin n_bad++; $display("FAIL b2b_accept_cyc: got %0d want %0d", acc_cyc[1], hs_cyc[1]); end
      n_vec++;
      if (hs_cyc[2] - hs_cyc[0] != 2) begin n_bad++; $display("FAIL b2b_bubble: got span %0d want 2", hs_cyc[2] - hs_cyc[0]); end
    end
    n_vec++;
    if (tready_busy != 2) begin n_bad++; $display("FAIL b2b_tready_pulses: got %0d want 2", tready_busy); end
  endtask

  task automatic test_null_last();
    clear_run();
    model_push(32'h00000000, 1'b1);
    run_stream(0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL null_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL null_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++;
    if ({pkt_cnt, gap_cnt, err_cnt, err_flag} !== exp_stats()) begin
      n_bad++; $display("FAIL null_stats: got %h want %h", {pkt_cnt, gap_cnt, err_cnt, err_flag}, exp_stats());
    end
  endtask

  task automatic test_malformed();
    clear_run();
    model_push(32'h00123456, 1'b0);
    model_push(32'h02000007, 1'b1);
    model_push(32'h01000000, 1'b0);
    run_stream(2);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL malformed_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL malformed_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++;
    if ({pkt_cnt, gap_cnt, err_cnt, err_flag} !== exp_stats()) begin
      n_bad++; $display("FAIL malformed_stats: got %h want %h", {pkt_cnt, gap_cnt, err_cnt, err_flag}, exp_stats());
    end
  endtask

  task automatic test_long_stall();
    clear_run();
    model_push(32'hFF00AAAA, 1'b0);
    run_stream(1);
    n_vec++;
    if (obs_q.size() != 255) begin
      n_bad++; $display("FAIL stall_count: got %0d want 255", obs_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++;
    if (stall_bad != 0) begin n_bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_bad); end
    n_vec++;
    if (tready_busy != 1) begin n_bad++; $display("FAIL stall_tready: got %0d busy-ready cycles want 1", tready_busy); end
  endtask

  task automatic test_full_run_chain();
    clear_run();
    model_push(32'hFF000042, 1'b0);
    model_push(32'hFF000042, 1'b1);
    run_stream(0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL chain_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL chain_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      n_vec++;
      if (hs_cyc[509] - hs_cyc[0] != 509) begin
        n_bad++; $display("FAIL chain_continuous: got span %0d want 509", hs_cyc[509] - hs_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_run();
    @(negedge axis_clk);
    s_tvalid = 1'b1; s_tdata = 32'h0A000011; s_tlast = 1'b0; smp_ready = 1'b1;
    @(negedge axis_clk);
    s_tvalid = 1'b0; s_tdata = 32'h0;
    #1;
    n_vec++;
    if ({smp_valid, smp_data} !== {1'b1, 24'h000011}) begin
      n_bad++; $display("FAIL midrst_first: got %h want %h", {smp_valid, smp_data}, {1'b1, 24'h000011});
    end
    @(negedge axis_clk);
    @(negedge axis_clk);
    #1;
    axis_rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({smp_valid, smp_data, s_tready} !== {1'b0, 24'h0, 1'b1}) begin
      n_bad++; $display("FAIL midrst_drop: got %h want %h", {smp_valid, smp_data, s_tready}, {1'b0, 24'h0, 1'b1});
    end
    n_vec++;
    if ({pkt_cnt, gap_cnt, err_cnt, err_flag} !== 49'h0) begin
      n_bad++; $display("FAIL midrst_stats: got %h want 0", {pkt_cnt, gap_cnt, err_cnt, err_flag});
    end
    @(negedge axis_clk);
    axis_rst = 1'b0; smp_ready = 1'b0;
    model_push(32'h01000055, 1'b0);
    run_stream(0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    logic [31:0] r32;
    int          kind;
    clear_run();
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 9));
      r32  = $urandom();
      if (kind == 0)      p = 32'h0;
      else if (kind == 1) p = {8'h00, r32[23:0] | 24'h1};
      else if (kind == 2) p = {8'($urandom_range(1, 3)), 24'h0};
      else if (kind == 3) p = {8'($urandom_range(10, 30)), r32[23:0]};
      else                p = {8'($urandom_range(1, 4)), r32[23:0]};
      model_push(p, 1'($urandom_range(0, 1)));
    end
    run_stream(2);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_smp[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++;
    if (stall_bad != 0) begin n_bad++; $display("FAIL rand_stable: got %0d unstable cycles want 0", stall_bad); end
    n_vec++;
    if ({pkt_cnt, gap_cnt, err_cnt, err_flag} !== exp_stats()) begin
      n_bad++; $display("FAIL rand_stats: got %h want %h", {pkt_cnt, gap_cnt, err_cnt, err_flag}, exp_stats());
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_null_last();
    test_malformed();
    test_long_stall();
    test_full_run_chain();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
